ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- PS/2 keyboard receiver and scan-code decoder that sits directly upstream of the VGA test pattern generator.
- Samples the raw ps2_clk/ps2_data lines in the pixel clock domain and deframes 11-bit PS/2 frames.
- Tracks the E0 (extended) and F0 (break) prefixes and emits one decoded key event per complete code.
- Maintains held/released levels for the four extended arrow keys, which drive the square position logic.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples needed before the filtered ps2_clk changes state.
- TIMEOUT_CYCLES, 28375: idle clk cycles allowed between falling edges inside a frame before the frame is aborted (~1 ms at 28.375 MHz).
- TMO_W, 16: width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system/pixel clock (28.375 MHz).
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data line, asynchronous to clk.
- key_code  out  8  last decoded non-prefix scan code.
- key_ext  out  1  key_code was preceded by E0.
- key_break  out  1  key_code was preceded by F0 (key release).
- key_valid  out  1  one-cycle strobe; key_code, key_ext and key_break are valid in this cycle.
- frame_err  out  1  one-cycle strobe on a parity error, stop-bit error or timeout.
- arrow_up  out  1  level; E0 75 currently held.
- arrow_down  out  1  level; E0 72 currently held.
- arrow_left  out  1  level; E0 6B currently held.
- arrow_right  out  1  level; E0 74 currently held.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs are 0.
  - FSM goes to IDLE; bit counter, shift register, timeout counter and prefix flags are cleared.
  - Synchronizer and filter state are set to 1 (lines idle high).
  - Reset asserted mid-frame discards the partial frame; no strobe is produced.
- Input conditioning:
  - Each line passes through a 2-FF synchronizer.
  - Filtered clock: changes to the synchronized value only after FILTER_LEN consecutive equal samples.
  - A falling edge is filtered clock 1->0, detected as a one-cycle fall pulse.
  - Data is taken from the synchronized ps2_data in the cycle of the fall pulse.
- Frame FSM (advances only on fall pulse, except for timeout):
  - IDLE: data=0 -> DATA with bitcnt=0. data=1 (false start) -> stay in IDLE, no error.
  - DATA: shift the bit in LSB-first (bit 0 first). After the 8th bit -> PARITY.
  - PARITY: check odd parity over the 8 data bits plus the parity bit -> STOP.
  - STOP: if stop bit=1 and parity ok -> byte accepted. Otherwise frame_err pulses and the prefix flags clear. Either way -> IDLE.
- Timeout:
  - In DATA, PARITY or STOP, the counter increments every clk and clears on each fall pulse.
  - When it reaches TIMEOUT_CYCLES: FSM -> IDLE, frame_err pulses for one cycle, prefix flags clear.
  - The counter is held at 0 in IDLE.
- Byte handling (the cycle after the stop-bit fall pulse):
  - E0 sets ext_pend. F0 sets brk_pend. Neither produces key_valid.
  - Any other byte (including E1, which receives no special handling):
    - key_code=byte, key_ext=ext_pend, key_break=brk_pend, key_valid=1 for exactly one cycle.
    - ext_pend and brk_pend then clear.
  - key_code, key_ext and key_break hold their values until the next key_valid.
- Arrow levels:
  - Update in the same cycle as key_valid, and only when key_ext=1.
  - The matching arrow is set to !key_break.
  - Non-extended 75/72/6B/74 (keypad keys) do not affect the arrows.
  - Typematic repeats of a make code leave an arrow at 1.
- Latency: key_valid asserts 1 clk after the stop-bit fall pulse, which is FILTER_LEN+3 clk after the raw ps2_clk falling edge.
- Simultaneous events: a timeout and a fall pulse in the same cycle resolve as timeout; the fall pulse is ignored.

Test Plan:
- Send frame 0x1C (start 0, data LSB-first, parity 0, stop 1) with a 40 us bit period -> one key_valid, key_code=1C, key_ext=0, key_break=0, frame_err never asserts.
- Send E0, 75, then E0, F0, 75 -> arrow_up rises at the first key_valid (key_ext=1, key_break=0). It falls at the second key_valid (key_ext=1, key_break=1). No key_valid for prefix bytes.
- Send 0x1C with the parity bit flipped -> frame_err pulses once, no key_valid. A subsequent good 0x29 gives key_code=29.
- Send E0, then a frame with stop=0, then 74 -> frame_err pulses, ext_pend is cleared, and the 74 gives key_ext=0 with arrow_right remaining 0.
- Send start plus 4 data bits, then idle for 30000 cycles -> frame_err pulses at TIMEOUT_CYCLES, FSM returns to IDLE, and the next full frame 0x6B decodes correctly.
- Inject 3-cycle low glitches on ps2_clk while idle -> no state change. Assert reset mid-frame -> all outputs 0, and the next frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: line conditioning, frame deframing, E0/F0 prefix
// tracking, key event strobe and held levels for the four extended arrows.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 28375,
  parameter int TMO_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       frame_err,
  output logic       arrow_up,
  output logic       arrow_down,
  output logic       arrow_left,
  output logic       arrow_right
);

  localparam int FC_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic            clk_s1_q, clk_s2_q;
  logic            dat_s1_q, dat_s2_q;
  logic            filt_q, filt_d;
  logic            filt_prev_q;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  state_t          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_ok_q, par_ok_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [7:0]      code_q, code_d;
  logic            kext_q, kext_d;
  logic            kbrk_q, kbrk_d;
  logic            kval_q, kval_d;
  logic            ferr_q, ferr_d;
  logic            up_q, up_d;
  logic            dn_q, dn_d;
  logic            lf_q, lf_d;
  logic            rt_q, rt_d;
  logic            fall;
  logic            timeout;

  assign fall    = filt_prev_q & ~filt_q;
  assign timeout = (state_q != IDLE) &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES));

  always_comb begin
    filt_d   = filt_q;
    fcnt_d   = fcnt_q;
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_ok_d = par_ok_q;
    tmo_d    = tmo_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    code_d   = code_q;
    kext_d   = kext_q;
    kbrk_d   = kbrk_q;
    kval_d   = 1'b0;
    ferr_d   = 1'b0;
    up_d     = up_q;
    dn_d     = dn_q;
    lf_d     = lf_q;
    rt_d     = rt_q;

    if (clk_s2_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FC_W'(FILTER_LEN - 1)) begin
      filt_d = clk_s2_q;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end

    if (state_q == IDLE || fall) tmo_d = '0;
    else                         tmo_d = tmo_q + 1'b1;

    // Timeout wins over a coincident fall pulse
    if (timeout) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
      tmo_d   = '0;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ^{shift_q, dat_s2_q};
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s2_q && par_ok_q) begin
            unique case (1'b1)
              (shift_q == 8'hE0): ext_d = 1'b1;
              (shift_q == 8'hF0): brk_d = 1'b1;
              default: begin
                code_d = shift_q;
                kext_d = ext_q;
                kbrk_d = brk_q;
                kval_d = 1'b1;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
                if (ext_q) begin
                  unique case (shift_q)
                    8'h75:   up_d = !brk_q;
                    8'h72:   dn_d = !brk_q;
                    8'h6B:   lf_d = !brk_q;
                    8'h74:   rt_d = !brk_q;
                    default: ;
                  endcase
                end
              end
            endcase
          end else begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      code_q      <= '0;
      kext_q      <= 1'b0;
      kbrk_q      <= 1'b0;
      kval_q      <= 1'b0;
      ferr_q      <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      lf_q        <= 1'b0;
      rt_q        <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      code_q      <= code_d;
      kext_q      <= kext_d;
      kbrk_q      <= kbrk_d;
      kval_q      <= kval_d;
      ferr_q      <= ferr_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      lf_q        <= lf_d;
      rt_q        <= rt_d;
    end
  end

  assign key_code    = code_q;
  assign key_ext     = kext_q;
  assign key_break   = kbrk_q;
  assign key_valid   = kval_q;
  assign frame_err   = ferr_q;
  assign arrow_up    = up_q;
  assign arrow_down  = dn_q;
  assign arrow_left  = lf_q;
  assign arrow_right = rt_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: frames driven on the raw lines,
// expected key events queued at send time and popped on key_valid.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int FL  = 8;
  localparam int TMO = 28375;
  localparam int H   = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_valid, frame_err;
  logic       arrow_up, arrow_down, arrow_left, arrow_right;

  ps2_key_decoder #(
    .FILTER_LEN(FL),
    .TIMEOUT_CYCLES(TMO),
    .TMO_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .key_code(key_code),
    .key_ext(key_ext),
    .key_break(key_break),
    .key_valid(key_valid),
    .frame_err(frame_err),
    .arrow_up(arrow_up),
    .arrow_down(arrow_down),
    .arrow_left(arrow_left),
    .arrow_right(arrow_right)
  );

  always #17.5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] arr;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        ev;
  logic [3:0] arr_m = 4'b0;
  int         vectors = 0;
  int         miscompares = 0;
  int         err_seen = 0;
  int         err_exp = 0;
  longint     cyc = 0;
  longint     last_err_cyc = 0;
  longint     t_fall = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_key(input logic [7:0] c,
                            input logic e,
                            input logic b);
    if (e) begin
      case (c)
        8'h75:   arr_m[3] = !b;
        8'h72:   arr_m[2] = !b;
        8'h6B:   arr_m[1] = !b;
        8'h74:   arr_m[0] = !b;
        default: ;
      endcase
    end
    exp_q.push_back('{code: c, ext: e, brk: b, arr: arr_m});
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic bad_par,
                            input logic bad_stop,
                            input int half);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (half) @(negedge clk);
    ps2_data = 1'b1;
    repeat (4 * half) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [8:0] f;
    f = {b, 1'b0};
    for (int i = 0; i <= nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      t_fall = cyc;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic check_arrows(input string tag);
    check(tag, {arrow_up, arrow_down, arrow_left, arrow_right}, arr_m);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) begin
        err_seen++;
        last_err_cyc = cyc;
      end
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_key_valid", key_valid, 0);
        end else begin
          ev = exp_q.pop_front();
          check("key_code", key_code, ev.code);
          check("key_ext", key_ext, ev.ext);
          check("key_break", key_break, ev.brk);
          check("arrows_at_valid",
                {arrow_up, arrow_down, arrow_left, arrow_right},
                ev.arr);
        end
      end
    end
  end

  initial begin
    longint d;
    repeat (5) @(negedge clk);
    check("rst_key_code", key_code, 0);
    check("rst_flags", {key_ext, key_break, key_valid, frame_err}, 0);
    check_arrows("rst_arrows");
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // 0x1C at a 40 us bit period
    expect_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 568);
    check("t1_consumed", exp_q.size(), 0);
    check("t1_no_err", err_seen, 0);
    check("t1_code_held", key_code, 8'h1C);

    // E0 75 make, then E0 F0 75 break
    send_frame(8'hE0, 1'b0, 1'b0, H);
    check("t2_prefix_silent", exp_q.size(), 0);
    expect_key(8'h75, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, H);
    check("t2_up_held", arrow_up, 1);
    send_frame(8'hE0, 1'b0, 1'b0, H);
    send_frame(8'hF0, 1'b0, 1'b0, H);
    check("t2_up_still", arrow_up, 1);
    expect_key(8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b0, H);
    check("t2_up_released", arrow_up, 0);
    check("t2_consumed", exp_q.size(), 0);

    // Parity error then a good 0x29
    send_frame(8'h1C, 1'b1, 1'b0, H);
    err_exp++;
    check("t3_par_err", err_seen, err_exp);
    expect_key(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, H);
    check("t3_consumed", exp_q.size(), 0);

    // Stop-bit error clears a pending E0
    send_frame(8'hE0, 1'b0, 1'b0, H);
    send_frame(8'h12, 1'b0, 1'b1, H);
    err_exp++;
    check("t4_stop_err", err_seen, err_exp);
    expect_key(8'h74, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0, H);
    check("t4_right_low", arrow_right, 0);
    check("t4_consumed", exp_q.size(), 0);

    // Timeout after start plus four data bits
    send_partial(8'hA5, 4);
    repeat (30000) @(negedge clk);
    err_exp++;
    check("t5_tmo_err", err_seen, err_exp);
    d = last_err_cyc - t_fall;
    check("t5_tmo_window", (d >= TMO && d <= TMO + 20), 1);
    expect_key(8'h6B, 1'b0, 1'b0);
    send_frame(8'h6B, 1'b0, 1'b0, H);
    check("t5_consumed", exp_q.size(), 0);
    check_arrows("t5_arrows");

    // Short clock glitches while idle
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    check("t6_glitch_no_err", err_seen, err_exp);
    expect_key(8'h6B, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, H);
    send_frame(8'h6B, 1'b0, 1'b0, H);
    check_arrows("t6_left_held");
    check("t6_consumed", exp_q.size(), 0);

    // Reset in the middle of a frame
    send_partial(8'h3C, 3);
    reset = 1'b1;
    arr_m = 4'b0;
    repeat (3) @(negedge clk);
    check("t6_rst_code", key_code, 0);
    check("t6_rst_flags",
          {key_ext, key_break, key_valid, frame_err}, 0);
    check_arrows("t6_rst_arrows");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    expect_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, H);
    check("t6_consumed", exp_q.size(), 0);
    check("final_err_count", err_seen, err_exp);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
